capture_mc: RTL and testbench
=============================

# capture_mc

Multi-channel successor to the single-channel high-pulse capture block. It measures the high time of up to CHANNELS asynchronous echo or pulse inputs in clk cycles, with per-channel synchronisation, saturation and overflow flagging. Completed measurements are serialised through one valid/ready result port under round-robin arbitration. It sits between the transducer input pins and the ranging/host logic.

## Interface
Parameters:
- CHANNELS, 4: number of independent capture inputs (1..16).
- CNT_W, 16: counter and result width.
- SYNC_STAGES, 2: synchroniser depth per input (≥2).
- TIMEOUT, 16'hFFFF: maximum measured high time in cycles. Used only with CAPTURE_TIMEOUT_EN; must be < 2^CNT_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cap_signal  in  CHANNELS  raw asynchronous inputs, bit i = channel i.
- enable  in  CHANNELS  per-channel level enable.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result when high together with out_valid.
- out_ch  out  CH_W  channel index of the result; CH_W = max(1, clog2(CHANNELS)).
- out_cnt  out  CNT_W  measured high time in cycles.
- out_ovf  out  1  counter saturated during the measurement.
- out_tmo  out  1  measurement ended by timeout.
- busy  out  CHANNELS  bit i high while channel i is in MEAS.

## Operation
- Per channel, s is the input after SYNC_STAGES flops and s_d is s delayed by one cycle.
  - Rise = s & ~s_d.
  - Synchroniser flops and s_d reset to 0.
- Channel FSM, reset state ARM:
  - ARM: wait for the line to be low. Go to IDLE when s=0 and enable=1.
  - IDLE: on rise with enable=1, go to MEAS and load cnt=1, ovf=0, tmo=0.
  - MEAS, s=1: cnt increments, saturating at 2^CNT_W-1. On an increment attempt at the saturated value, set ovf=1 and hold cnt.
  - MEAS, s=0: go to HOLD. cnt equals the number of cycles s was high.
  - HOLD: result is pending. Edges are ignored. On grant, go to ARM.
- enable=0 in ARM, IDLE or MEAS forces ARM and discards the measurement. A pending HOLD result is kept until it is granted.
- Output register:
  - Loads when out_valid=0, or when out_valid=1 and out_ready=1.
  - Source is the round-robin winner among HOLD channels, searched from pointer p upward, wrapping.
  - When channel k is granted, p becomes (k+1) mod CHANNELS and k leaves HOLD on the same edge.
  - If no channel is in HOLD, out_valid falls after acceptance.
- out_ch, out_cnt, out_ovf and out_tmo are stable while out_valid=1 and out_ready=0.
- Simultaneous accept and new HOLD: the new result loads on the same edge, so back-to-back results sustain one per cycle.

## Timing
- Reset values: out_valid=0, out_ch=0, out_cnt=0, out_ovf=0, out_tmo=0, busy=0, p=0, all channels in ARM.
- A reset mid-measurement discards everything and returns all channels to ARM.
- A line held high through reset produces no spurious measurement.
- Latency:
  - A raw input edge reaches s after SYNC_STAGES cycles.
  - The first cycle with s=0 in MEAS enters HOLD on the next edge.
  - out_valid rises one edge later if the output register is free.
- A clean synchronous high pulse of P cycles yields out_cnt=P.

## Configuration
- CAPTURE_TIMEOUT_EN defined:
  - In MEAS, when cnt=TIMEOUT and s=1, go to HOLD with cnt=TIMEOUT and tmo=1.
  - After the grant, ARM waits for the line to fall, so a stuck-high line yields exactly one timeout result per high period.
- CAPTURE_TIMEOUT_EN undefined:
  - No timeout logic is built and out_tmo is tied to 0.
  - A stuck-high line saturates and is reported only on its fall.

## Structure
- Package capture_pkg: FSM state encodings (ARM=2'd0, IDLE=2'd1, MEAS=2'd2, HOLD=2'd3) and a ch_width function for CH_W.
- Sub-module capture_channel: synchroniser, edge detect, FSM and counter for one channel. It exports hold, cnt, ovf and tmo, and takes a grant input.
- capture_mc instantiates CHANNELS copies and contains the round-robin arbiter and the output register.

## Test plan
- Reset with ch0 held high, then released → no result. A later 5-cycle pulse on ch0 → out_ch=0, out_cnt=5, ovf=0.
- CNT_W=4, 20-cycle pulse → out_cnt=15, out_ovf=1.
- Pulses ending on the same cycle on ch0..ch3, out_ready=1 → results in order ch0, ch1, ch2, ch3 on consecutive cycles. Repeat → order starts at the pointer.
- out_ready=0 for 10 cycles with ch1 pending → outputs stable. A second ch1 pulse during HOLD is ignored. Release → exactly one result.
- enable[2] dropped mid-pulse → no result from ch2. A HOLD result already pending on ch2 is still delivered.
- CAPTURE_TIMEOUT_EN, TIMEOUT=100, ch3 held high for 300 cycles → one result with out_cnt=100 and out_tmo=1. No further result until ch3 falls and a new pulse occurs.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared definitions for the multi-channel pulse-width capture block:
// channel FSM encodings and the channel-index width helper.
package capture_pkg;

    localparam logic [1:0] ARM  = 2'd0;
    localparam logic [1:0] IDLE = 2'd1;
    localparam logic [1:0] MEAS = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/capture_channel.sv
// One capture channel: input synchroniser, rise detect, ARM/IDLE/MEAS/HOLD FSM
// and saturating high-time counter. Timeout abort is built with CAPTURE_TIMEOUT_EN.
module capture_channel
    import capture_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_signal,
    input  logic             enable,
    input  logic             grant,
    output logic             hold,
    output logic             busy,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    output logic             tmo
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);
`ifdef CAPTURE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] vld_reg;
    logic                   s_d_reg;
    logic                   s;
    logic                   sync_ok;
    logic                   rise;
    logic                   tmo_hit;
    logic [1:0]             state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   ovf_reg, ovf_next;
    logic                   tmo_reg, tmo_next;

    // vld_reg marks when s reflects a sample taken after reset, so a line held
    // high through reset is not mistaken for a low line while the chain refills.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= '0;
            vld_reg  <= '0;
            s_d_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], cap_signal};
            vld_reg  <= {vld_reg[SYNC_STAGES-2:0], 1'b1};
            s_d_reg  <= s;
        end
    end

    assign s       = sync_reg[SYNC_STAGES-1];
    assign sync_ok = vld_reg[SYNC_STAGES-1];
    assign rise    = s & ~s_d_reg;
    assign tmo_hit = TMO_EN && (cnt_reg == TMO_LIMIT);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        tmo_next   = tmo_reg;
        case (state_reg)
            ARM: begin
                if (enable && sync_ok && !s) state_next = IDLE;
            end
            IDLE: begin
                if (!enable) begin
                    state_next = ARM;
                end else if (rise) begin
                    state_next = MEAS;
                    cnt_next   = CNT_W'(1);
                    ovf_next   = 1'b0;
                    tmo_next   = 1'b0;
                end
            end
            MEAS: begin
                if (!enable) begin
                    state_next = ARM;
                end else if (!s) begin
                    state_next = HOLD;
                end else if (tmo_hit) begin
                    state_next = HOLD;
                    tmo_next   = 1'b1;
                end else if (cnt_reg == CNT_MAX) begin
                    ovf_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HOLD: begin
                // Result is frozen here; edges and enable are ignored until granted.
                if (grant) state_next = ARM;
            end
            default: state_next = ARM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ARM;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            tmo_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
            tmo_reg   <= tmo_next;
        end
    end

    assign hold = (state_reg == HOLD);
    assign busy = (state_reg == MEAS);
    assign cnt  = cnt_reg;
    assign ovf  = ovf_reg;
    assign tmo  = tmo_reg;

endmodule

// File: rtl/capture_mc.sv
// Multi-channel high-time capture: CHANNELS capture_channel instances, a
// round-robin arbiter and one valid/ready result register. Timeout: CAPTURE_TIMEOUT_EN.
module capture_mc
    import capture_pkg::*;
#(
    parameter int  CHANNELS    = 4,
    parameter int  CNT_W       = 16,
    parameter int  SYNC_STAGES = 2,
    parameter int  TIMEOUT     = 'hFFFF,
    localparam int CH_W        = ch_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] cap_signal,
    input  logic [CHANNELS-1:0] enable,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_ch,
    output logic [CNT_W-1:0]    out_cnt,
    output logic                out_ovf,
    output logic                out_tmo,
    output logic [CHANNELS-1:0] busy
);

    logic [CHANNELS-1:0] ch_hold;
    logic [CHANNELS-1:0] ch_ovf;
    logic [CHANNELS-1:0] ch_tmo;
    logic [CHANNELS-1:0] grant;
    logic [CNT_W-1:0]    ch_cnt [CHANNELS];

    logic [CH_W-1:0]  ptr_reg, ptr_next;
    logic [CH_W-1:0]  win;
    logic [CH_W-1:0]  idx;
    logic             any_hold;
    logic             load;
    logic             out_valid_reg;
    logic [CH_W-1:0]  out_ch_reg;
    logic [CNT_W-1:0] out_cnt_reg;
    logic             out_ovf_reg;
    logic             out_tmo_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            capture_channel #(
                .CNT_W      (CNT_W),
                .SYNC_STAGES(SYNC_STAGES),
                .TIMEOUT    (TIMEOUT)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .cap_signal(cap_signal[gi]),
                .enable    (enable[gi]),
                .grant     (grant[gi]),
                .hold      (ch_hold[gi]),
                .busy      (busy[gi]),
                .cnt       (ch_cnt[gi]),
                .ovf       (ch_ovf[gi]),
                .tmo       (ch_tmo[gi])
            );
        end
    endgenerate

    // Scan downward so the last hit written is the nearest one at/after ptr_reg.
    always_comb begin
        any_hold = 1'b0;
        win      = '0;
        idx      = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (int'(ptr_reg) + i >= CHANNELS) idx = CH_W'(int'(ptr_reg) + i - CHANNELS);
            else                               idx = CH_W'(int'(ptr_reg) + i);
            if (ch_hold[idx]) begin
                any_hold = 1'b1;
                win      = idx;
            end
        end
    end

    assign load = !out_valid_reg || out_ready;

    always_comb begin
        grant = '0;
        if (load && any_hold) grant[win] = 1'b1;
        if (win == CH_W'(CHANNELS - 1)) ptr_next = '0;
        else                            ptr_next = win + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_reg <= 1'b0;
            out_ch_reg    <= '0;
            out_cnt_reg   <= '0;
            out_ovf_reg   <= 1'b0;
            out_tmo_reg   <= 1'b0;
            ptr_reg       <= '0;
        end else if (load) begin
            out_valid_reg <= any_hold;
            if (any_hold) begin
                out_ch_reg  <= win;
                out_cnt_reg <= ch_cnt[win];
                out_ovf_reg <= ch_ovf[win];
                out_tmo_reg <= ch_tmo[win];
                ptr_reg     <= ptr_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_ch    = out_ch_reg;
    assign out_cnt   = out_cnt_reg;
    assign out_ovf   = out_ovf_reg;
    assign out_tmo   = out_tmo_reg;

endmodule

// File: tb/tb_capture_mc.sv
// Bench for capture_mc: a 4-channel instance (TIMEOUT=100) and a 1-channel
// CNT_W=4 instance, each with a scoreboard queue popped on output handshakes.
module tb_capture_mc;

`ifdef CAPTURE_TIMEOUT_EN
    localparam bit TMO_BUILD = 1'b1;
`else
    localparam bit TMO_BUILD = 1'b0;
`endif

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] cnt;
        logic        ovf;
        logic        tmo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cap, enable, busy;
    logic        out_valid, out_ready, out_ovf, out_tmo;
    logic [1:0]  out_ch;
    logic [15:0] out_cnt;

    logic [0:0]  cap4, en4, busy4, out_ch4;
    logic        out_valid4, out_ready4, out_ovf4, out_tmo4;
    logic [3:0]  out_cnt4;

    exp_t sb[$];
    exp_t sb4[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    capture_mc #(.CHANNELS(4), .CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .cap_signal(cap), .enable(enable),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_cnt(out_cnt), .out_ovf(out_ovf), .out_tmo(out_tmo), .busy(busy)
    );

    capture_mc #(.CHANNELS(1), .CNT_W(4), .SYNC_STAGES(2), .TIMEOUT(15)) dut4 (
        .clk(clk), .rst(rst), .cap_signal(cap4), .enable(en4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_ch(out_ch4),
        .out_cnt(out_cnt4), .out_ovf(out_ovf4), .out_tmo(out_tmo4), .busy(busy4)
    );

    // Scoreboard for the 4-channel instance.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t e;
            n_cmp++;
            $display("txn main ch=%0d cnt=%0d ovf=%0b tmo=%0b", out_ch, out_cnt, out_ovf, out_tmo);
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL main_unexpected: got ch=%0d cnt=%0d, required no result", out_ch, out_cnt);
            end else begin
                e = sb.pop_front();
                if ({out_ch, out_cnt, out_ovf, out_tmo} !== {e.ch, e.cnt, e.ovf, e.tmo}) begin
                    n_err++;
                    $display("FAIL main_result: got ch=%0d cnt=%0d ovf=%0b tmo=%0b, required ch=%0d cnt=%0d ovf=%0b tmo=%0b",
                             out_ch, out_cnt, out_ovf, out_tmo, e.ch, e.cnt, e.ovf, e.tmo);
                end
            end
        end
    end

    // Scoreboard for the CNT_W=4 instance.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid4 === 1'b1 && out_ready4 === 1'b1) begin
            exp_t e;
            n_cmp++;
            $display("txn cnt4 ch=%0d cnt=%0d ovf=%0b tmo=%0b", out_ch4, out_cnt4, out_ovf4, out_tmo4);
            if (sb4.size() == 0) begin
                n_err++;
                $display("FAIL cnt4_unexpected: got cnt=%0d, required no result", out_cnt4);
            end else begin
                e = sb4.pop_front();
                if ({1'b0, out_ch4, 12'd0, out_cnt4, out_ovf4, out_tmo4} !== {e.ch, e.cnt, e.ovf, e.tmo}) begin
                    n_err++;
                    $display("FAIL cnt4_result: got cnt=%0d ovf=%0b tmo=%0b, required cnt=%0d ovf=%0b tmo=%0b",
                             out_cnt4, out_ovf4, out_tmo4, e.cnt, e.ovf, e.tmo);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_main(input int ch, input int cnt, input bit ovf, input bit tmo);
        sb.push_back('{ch[1:0], cnt[15:0], ovf, tmo});
    endtask

    task automatic expect_cnt4(input int cnt, input bit ovf, input bit tmo);
        sb4.push_back('{2'd0, cnt[15:0], ovf, tmo});
    endtask

    task automatic pulse(input int ch, input int len);
        cap[ch] = 1'b1;
        cycles(len);
        cap[ch] = 1'b0;
    endtask

    task automatic pulse4(input int len);
        cap4 = 1'b1;
        cycles(len);
        cap4 = 1'b0;
    endtask

    // Bounded waits: ok=0 when the budget runs out.
    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && out_valid === 1'b0 && sb4.size() == 0 && out_valid4 === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        cycles(1);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b0; cap = 4'b0001; enable = '1; out_ready = 1'b1;
        cap4 = 1'b0; en4 = 1'b1; out_ready4 = 1'b1;
        cycles(3);
        n_cmp++;
        if ({out_valid, out_ch, out_cnt, out_ovf, out_tmo, busy} !== 25'd0) begin
            n_err++;
            $display("FAIL reset_values: got valid=%0b ch=%0d cnt=%0d ovf=%0b tmo=%0b busy=%b, required all 0",
                     out_valid, out_ch, out_cnt, out_ovf, out_tmo, busy);
        end
        rst = 1'b1;
        cycles(10);
        cap[0] = 1'b0;
        cycles(10);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 4'd0) begin
            n_err++;
            $display("FAIL held_through_reset: got valid=%0b busy=%b, required 0/0000", out_valid, busy);
        end
        expect_main(0, 5, 1'b0, 1'b0);
        pulse(0, 5);
        wait_drain(60, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL first_pulse_drain: got timeout, required result"); end
        // Reset mid-measurement on ch1 with the line still high afterwards.
        cap[1] = 1'b1;
        cycles(6);
        n_cmp++;
        if (busy[1] !== 1'b1) begin n_err++; $display("FAIL busy_meas: got %0b, required 1", busy[1]); end
        rst = 1'b0;
        cycles(1);
        n_cmp++;
        if (busy !== 4'd0) begin n_err++; $display("FAIL busy_in_reset: got %b, required 0000", busy); end
        cycles(2);
        rst = 1'b1;
        cycles(5);
        cap[1] = 1'b0;
        cycles(15);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_discard: got valid=%0b, required 0", out_valid); end
    endtask

    task automatic test_saturate();
        bit ok;
        int lens[4] = '{1, 15, 16, 20};
        foreach (lens[i]) begin
            if (lens[i] <= 15)   expect_cnt4(lens[i], 1'b0, 1'b0);
            else if (TMO_BUILD)  expect_cnt4(15, 1'b0, 1'b1);
            else                 expect_cnt4(15, 1'b1, 1'b0);
            pulse4(lens[i]);
            wait_drain(60, ok);
            n_cmp++;
            if (!ok) begin n_err++; $display("FAIL saturate_drain len=%0d: got timeout, required result", lens[i]); end
        end
    endtask

    task automatic burst_and_count(input string tag);
        bit ok;
        int run;
        cap[3] = 1'b1; cycles(2);
        cap[2] = 1'b1; cycles(2);
        cap[1] = 1'b1; cycles(2);
        cap[0] = 1'b1; cycles(3);
        cap = 4'b0000;
        wait_valid(30, ok);
        run = 0;
        while (ok && out_valid === 1'b1 && run < 10) begin
            run++;
            @(negedge clk);
        end
        n_cmp++;
        if (run != 4) begin n_err++; $display("FAIL %s_consecutive: got %0d cycles, required 4", tag, run); end
        wait_drain(40, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL %s_drain: got timeout, required empty", tag); end
    endtask

    task automatic test_round_robin();
        bit ok;
        // Pointer is 0 here (last reset); lengths ch0=3 ch1=5 ch2=7 ch3=9.
        expect_main(0, 3, 0, 0); expect_main(1, 5, 0, 0);
        expect_main(2, 7, 0, 0); expect_main(3, 9, 0, 0);
        burst_and_count("rr_p0");
        expect_main(1, 4, 0, 0);
        pulse(1, 4);
        wait_drain(60, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rr_single_drain: got timeout, required result"); end
        // Pointer now 2.
        expect_main(2, 7, 0, 0); expect_main(3, 9, 0, 0);
        expect_main(0, 3, 0, 0); expect_main(1, 5, 0, 0);
        burst_and_count("rr_p2");
    endtask

    task automatic test_backpressure();
        bit ok;
        out_ready = 1'b0;
        expect_main(0, 4, 0, 0);
        pulse(0, 4);
        wait_valid(30, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL bp_first_valid: got timeout, required valid"); end
        cycles(1);
        cap[1] = 1'b1;
        cycles(3);
        n_cmp++;
        if (busy[1] !== 1'b1) begin n_err++; $display("FAIL bp_busy1: got %0b, required 1", busy[1]); end
        cycles(4);
        cap[1] = 1'b0;
        expect_main(1, 7, 0, 0);
        cycles(5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 2) cap[1] = 1'b1;
            if (i == 6) cap[1] = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_cnt !== 16'd4) begin
                n_err++;
                $display("FAIL bp_stable cycle=%0d: got valid=%0b ch=%0d cnt=%0d, required 1/0/4",
                         i, out_valid, out_ch, out_cnt);
            end
            if (i == 5) begin
                n_cmp++;
                if (busy[1] !== 1'b0) begin n_err++; $display("FAIL bp_hold_ignores_edge: got busy=%0b, required 0", busy[1]); end
            end
        end
        cycles(1);
        out_ready = 1'b1;
        wait_drain(40, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL bp_drain: got timeout, required empty"); end
        cycles(10);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_single_result: got valid=%0b, required 0", out_valid); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        cap[2] = 1'b1;
        cycles(5);
        n_cmp++;
        if (busy[2] !== 1'b1) begin n_err++; $display("FAIL en_busy2: got %0b, required 1", busy[2]); end
        enable[2] = 1'b0;
        cycles(1);
        n_cmp++;
        if (busy[2] !== 1'b0) begin n_err++; $display("FAIL en_abort: got busy=%0b, required 0", busy[2]); end
        cycles(3);
        cap[2] = 1'b0;
        cycles(4);
        enable[2] = 1'b1;
        cycles(10);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL en_discard: got valid=%0b, required 0", out_valid); end
        out_ready = 1'b0;
        expect_main(0, 3, 0, 0);
        pulse(0, 3);
        cycles(6);
        expect_main(2, 6, 0, 0);
        pulse(2, 6);
        cycles(6);
        enable[2] = 1'b0;
        cycles(5);
        out_ready = 1'b1;
        wait_drain(40, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL en_hold_kept: got timeout, required ch2 result"); end
        enable[2] = 1'b1;
        cycles(5);
    endtask

    task automatic test_timeout();
        bit ok;
        if (TMO_BUILD) expect_main(3, 100, 1'b0, 1'b1);
        else           expect_main(3, 300, 1'b0, 1'b0);
        cap[3] = 1'b1;
        cycles(300);
        n_cmp++;
        if (sb.size() != (TMO_BUILD ? 0 : 1)) begin
            n_err++;
            $display("FAIL tmo_while_high: got %0d pending, required %0d", sb.size(), TMO_BUILD ? 0 : 1);
        end
        cap[3] = 1'b0;
        wait_drain(60, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL tmo_drain: got timeout, required empty"); end
        cycles(15);
        expect_main(3, 8, 0, 0);
        pulse(3, 8);
        wait_drain(60, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL tmo_next_pulse: got timeout, required result"); end
    endtask

    initial begin
        test_reset();
        test_saturate();
        test_round_robin();
        test_backpressure();
        test_enable_drop();
        test_timeout();
        cycles(10);
        n_cmp++;
        if (sb.size() != 0 || sb4.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected: got %0d/%0d pending, required 0/0", sb.size(), sb4.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
